// File: rtl/ser288to72_if.sv
// Frame-input / lane-output bundle of the 288:72 transmit serializer.
interface ser288to72_if #(
    parameter int W = 9
);
    logic              in_valid;
    logic              in_ready;
    logic [32*W-1:0]   in_data;
    logic [8*W-1:0]    out_data;
    logic              out_valid;
    logic              out_sof;
    logic              clkout;
    logic              underflow;
    logic              underflow_clr;

    modport master (
        output in_valid, in_data, underflow_clr,
        input  in_ready, out_data, out_valid, out_sof, clkout, underflow
    );

    modport slave (
        input  in_valid, in_data, underflow_clr,
        output in_ready, out_data, out_valid, out_sof, clkout, underflow
    );
endinterface

// File: rtl/ser288to72.sv
// 288:72 transmit serializer: one 32-word frame per four clocks onto eight lanes,
// with a one-deep input buffer, a frame-aligned divide-by-4 clock and underflow flag.
module ser288to72 #(
    parameter int           W    = 9,
    parameter logic [W-1:0] IDLE = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   phi_init,
    ser288to72_if.slave  bus
);
    localparam int NW = 32;
    localparam int NL = 8;

    typedef logic [NW*W-1:0] frame_t;
    typedef logic [NL*W-1:0] lanes_t;

    function automatic frame_t idle_frame();
        frame_t f;
        for (int j = 0; j < NW; j++) begin
            f[j*W +: W] = IDLE;
        end
        return f;
    endfunction

    // Even lanes carry the low half of the frame, odd lanes the high half,
    // four consecutive words per lane pair advance by four per slot.
    function automatic lanes_t slot_words(input frame_t f, input logic [1:0] s);
        lanes_t l;
        int     sidx;
        sidx = int'(s);
        for (int m = 0; m < 4; m++) begin
            l[(2*m)*W   +: W] = f[(m + 4*sidx)*W      +: W];
            l[(2*m+1)*W +: W] = f[(16 + m + 4*sidx)*W +: W];
        end
        return l;
    endfunction

    logic [1:0] phi_q,          phi_d;
    frame_t     pend_q,         pend_d;
    logic       pend_full_q,    pend_full_d;
    frame_t     active_q,       active_d;
    logic       active_valid_q, active_valid_d;
    logic       started_q,      started_d;
    lanes_t     out_data_q,     out_data_d;
    logic       out_valid_q,    out_valid_d;
    logic       out_sof_q,      out_sof_d;
    logic       clkout_q,       clkout_d;
    logic       underflow_q,    underflow_d;

    logic       boundary_s;
    logic       ready_s;
    logic       xfer_s;
    logic       uf_set_s;

    assign boundary_s = (phi_q == 2'd3);
    assign ready_s    = !pend_full_q || boundary_s;
    assign xfer_s     = bus.in_valid && ready_s;

    // Next-state: buffer/active frame handover, output slot selection, flags.
    always_comb begin
        phi_d          = phi_q + 2'd1;
        pend_d         = pend_q;
        pend_full_d    = pend_full_q;
        active_d       = active_q;
        active_valid_d = active_valid_q;
        started_d      = started_q;
        uf_set_s       = 1'b0;
        underflow_d    = underflow_q;

        if (xfer_s) begin
            pend_d = bus.in_data;
        end else begin
            pend_d = pend_q;
        end

        if (boundary_s) begin
            pend_full_d = xfer_s;
            if (pend_full_q) begin
                active_d       = pend_q;
                active_valid_d = 1'b1;
                started_d      = 1'b1;
            end else begin
                active_d       = idle_frame();
                active_valid_d = 1'b0;
                uf_set_s       = started_q;
            end
        end else begin
            pend_full_d = pend_full_q || xfer_s;
        end

        // The outgoing frame still drives slot 3 on the boundary edge.
        out_data_d  = slot_words(active_q, phi_q);
        out_valid_d = active_valid_q;
        out_sof_d   = (phi_q == 2'd0) && active_valid_q;
        clkout_d    = (phi_q == 2'd0) || (phi_q == 2'd1);

        if (bus.underflow_clr) begin
            underflow_d = 1'b0;
        end else if (uf_set_s) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State and output registers; reset discards both frames at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi_q          <= phi_init;
            pend_q         <= idle_frame();
            pend_full_q    <= 1'b0;
            active_q       <= idle_frame();
            active_valid_q <= 1'b0;
            started_q      <= 1'b0;
            out_data_q     <= {NL{IDLE}};
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            clkout_q       <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            phi_q          <= phi_d;
            pend_q         <= pend_d;
            pend_full_q    <= pend_full_d;
            active_q       <= active_d;
            active_valid_q <= active_valid_d;
            started_q      <= started_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            out_sof_q      <= out_sof_d;
            clkout_q       <= clkout_d;
            underflow_q    <= underflow_d;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.clkout    = clkout_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_ser288to72.sv
// Bench for ser288to72: frame-queue reference model checked every cycle, a
// behavioural 72:288 deserializer for loopback, and hand-computed spot checks.
module tb_ser288to72;
    localparam int W = 9;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic [1:0] phi_init = 2'd0;

    ser288to72_if #(.W(W)) bus ();

    ser288to72 #(.W(W), .IDLE(9'd0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .phi_init (phi_init),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [287:0] frame_seq(input int base);
        logic [287:0] f;
        for (int j = 0; j < 32; j++) f[9*j +: 9] = 9'(base + j);
        return f;
    endfunction

    function automatic logic [287:0] frame_rand();
        logic [287:0] f;
        for (int j = 0; j < 32; j++) f[9*j +: 9] = 9'($urandom_range(0, 511));
        return f;
    endfunction

    // Reference model: frames queued in acceptance order, one frame played per 4 cycles.
    int           m_phi;
    logic [8:0]   m_act [32];
    bit           m_av, m_started, m_uf;
    logic [287:0] m_pend [$];
    logic [287:0] lb_q [$];
    logic [71:0]  e_data;
    bit           e_valid, e_sof, e_clk;
    bit           cmp_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phi = int'(phi_init);
            m_pend.delete();
            lb_q.delete();
            foreach (m_act[j]) m_act[j] = 9'd0;
            m_av = 1'b0; m_started = 1'b0; m_uf = 1'b0;
            e_data = 72'd0; e_valid = 1'b0; e_sof = 1'b0; e_clk = 1'b0;
        end else begin
            bit           rdy, xfer, uf_set;
            logic [287:0] f;
            rdy    = (m_pend.size() == 0) || (m_phi == 3);
            xfer   = bus.in_valid && rdy;
            uf_set = 1'b0;
            for (int k = 0; k < 8; k++)
                e_data[9*k +: 9] = m_act[(k % 2) * 16 + k / 2 + 4 * m_phi];
            e_valid = m_av;
            e_sof   = (m_phi == 0) && m_av;
            e_clk   = (m_phi < 2);
            if (m_phi == 3) begin
                if (m_pend.size() > 0) begin
                    f = m_pend.pop_front();
                    for (int j = 0; j < 32; j++) m_act[j] = f[9*j +: 9];
                    m_av = 1'b1;
                    m_started = 1'b1;
                end else begin
                    foreach (m_act[j]) m_act[j] = 9'd0;
                    m_av = 1'b0;
                    uf_set = m_started;
                end
            end
            if (xfer) begin
                m_pend.push_back(bus.in_data);
                lb_q.push_back(bus.in_data);
            end
            if (bus.underflow_clr) m_uf = 1'b0;
            else if (uf_set) m_uf = 1'b1;
            m_phi = (m_phi + 1) % 4;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_data",  bus.out_data,  e_data);
            chk("out_valid", bus.out_valid, e_valid);
            chk("out_sof",   bus.out_sof,   e_sof);
            chk("clkout",    bus.clkout,    e_clk);
            chk("underflow", bus.underflow, m_uf);
            chk("in_ready",  bus.in_ready,  (m_pend.size() == 0) || (m_phi == 3));
        end
    end

    // Behavioural receive-side deserializer: rebuild frames, match acceptance order.
    int           rx_slot = -1;
    int           frames_rx = 0;
    logic [287:0] rx;
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_slot = -1;
        end else if (bus.out_valid) begin
            if (bus.out_sof) rx_slot = 0;
            else if (rx_slot >= 0) rx_slot++;
            if (rx_slot >= 0 && rx_slot <= 3) begin
                for (int m = 0; m < 4; m++) begin
                    rx[9*(m + 4*rx_slot) +: 9]      = bus.out_data[9*(2*m) +: 9];
                    rx[9*(16 + m + 4*rx_slot) +: 9] = bus.out_data[9*(2*m+1) +: 9];
                end
                if (rx_slot == 3) begin
                    chk("loopback_has_frame", lb_q.size() != 0, 1'b1);
                    if (lb_q.size() != 0) chk("loopback_frame", rx, lb_q.pop_front());
                    frames_rx++;
                    rx_slot = -1;
                end
            end
        end else begin
            rx_slot = -1;
        end
    end

    task automatic wait_phase(input int p);
        int n = 0;
        while (m_phi != p && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("wait_phase", m_phi == p, 1'b1);
    endtask

    task automatic send(input logic [287:0] f);
        int n = 0;
        bus.in_data  = f;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_timeout", bus.in_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_sof();
        int n = 0;
        while (!bus.out_sof && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("sof_timeout", bus.out_sof, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int run;
        int n;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.underflow_clr = 1'b0;

        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_data",  bus.out_data,  72'd0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_sof",   bus.out_sof,   1'b0);
        chk("rst_clkout",    bus.clkout,    1'b0);
        chk("rst_underflow", bus.underflow, 1'b0);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_edge_clkout", bus.clkout, 1'b1);
        repeat (8) @(negedge clk);
        chk("idle_no_underflow", bus.underflow, 1'b0);

        // Single frame, word j = j, offered at phi==3.
        wait_phase(3);
        send(frame_seq(0));
        bus.in_valid = 1'b0;
        wait_sof();
        for (int s = 0; s < 4; s++) begin
            chk("single_lane0", bus.out_data[0  +: 9], 9'(4*s));
            chk("single_lane1", bus.out_data[9  +: 9], 9'(16 + 4*s));
            chk("single_lane6", bus.out_data[54 +: 9], 9'(3 + 4*s));
            chk("single_lane7", bus.out_data[63 +: 9], 9'(19 + 4*s));
            chk("single_sof",   bus.out_sof,  s == 0);
            chk("single_clkout", bus.clkout,  s < 2);
            @(negedge clk);
        end
        chk("single_then_underflow", bus.underflow, 1'b1);
        bus.underflow_clr = 1'b1;
        @(negedge clk);
        bus.underflow_clr = 1'b0;
        chk("clr_after_single", bus.underflow, 1'b0);

        // Back-to-back frames with in_valid held: no IDLE gap.
        fork
            begin
                for (int i = 0; i < 4; i++) send(frame_seq(32 * (i + 1)));
                bus.in_valid = 1'b0;
            end
            begin
                wait_sof();
                run = 0;
                repeat (16) begin
                    if (bus.out_valid) run++;
                    @(negedge clk);
                end
                chk("b2b_valid_run", run, 16);
            end
        join

        // Two frames then stop: underflow, IDLE, clear behaviour.
        wait_phase(1);
        bus.underflow_clr = 1'b1;
        send(frame_seq(200));
        bus.underflow_clr = 1'b0;
        send(frame_seq(300));
        bus.in_valid = 1'b0;
        wait_sof();
        n = 0;
        while (bus.out_valid && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("stop_out_valid",  bus.out_valid, 1'b0);
        chk("stop_out_data",   bus.out_data,  72'd0);
        chk("stop_underflow",  bus.underflow, 1'b1);
        bus.underflow_clr = 1'b1;
        @(negedge clk);
        bus.underflow_clr = 1'b0;
        chk("uf_cleared", bus.underflow, 1'b0);
        wait_phase(3);
        bus.underflow_clr = 1'b1;
        @(negedge clk);
        bus.underflow_clr = 1'b0;
        chk("uf_clr_priority", bus.underflow, 1'b0);
        wait_phase(3);
        @(negedge clk);
        chk("uf_set_again", bus.underflow, 1'b1);
        bus.underflow_clr = 1'b1;
        @(negedge clk);
        bus.underflow_clr = 1'b0;

        // Second frame offered at phi==1 with the buffer full.
        wait_phase(0);
        send(frame_seq(400));
        bus.in_data  = frame_seq(100);
        bus.in_valid = 1'b1;
        chk("ready_low_when_full", bus.in_ready, 1'b0);
        send(frame_seq(100));
        bus.in_valid = 1'b0;
        repeat (12) @(negedge clk);

        // Random stream with an asynchronous reset in the middle.
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                bus.in_valid = 1'b0;
                #3 rst_n = 1'b0;
                #1;
                chk("async_rst_data",  bus.out_data,  72'd0);
                chk("async_rst_valid", bus.out_valid, 1'b0);
                chk("async_rst_sof",   bus.out_sof,   1'b0);
                phi_init = 2'd2;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            send(frame_rand());
        end
        bus.in_valid = 1'b0;
        repeat (16) @(negedge clk);
        chk("loopback_drained", lb_q.size(), 0);
        chk("loopback_frames_seen", frames_rx > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
